sram_ctrl: RTL

SRAM_CTRL -- requirements
Module: sram_ctrl

---
 rtl/sram_ctrl.sv | 131 +++++++++++++
 1 files changed

// File: rtl/sram_ctrl.sv
// Bus-to-async-SRAM bridge: one word access at a time,
// fixed read/write wait states, all SRAM pins registered.
module sram_ctrl #(
  parameter int READ_WAIT  = 2,
  parameter int WRITE_WAIT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [23:0] ram_addr,
  input  logic [3:0]  ram_byte_en,
  input  logic [31:0] write_data_to_ram,
  input  logic        ram_read_enable,
  input  logic        ram_write_enable,
  output logic [31:0] read_data_from_ram,
  output logic        ram_stall,
  output logic [19:0] sram_addr,
  output logic [31:0] sram_dq_o,
  input  logic [31:0] sram_dq_i,
  output logic        sram_dq_oe,
  output logic        sram_ce_n,
  output logic        sram_oe_n,
  output logic        sram_we_n,
  output logic [3:0]  sram_be_n
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    DONE
  } state_t;

  localparam logic [3:0] RD_LOAD = 4'(READ_WAIT - 1);
  localparam logic [3:0] WR_LOAD = 4'(WRITE_WAIT - 1);

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic [31:0] r_rdata;
  logic [19:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_be;
  logic        r_dq_oe;
  logic        r_ce_n;
  logic        r_oe_n;
  logic        r_we_n;
  logic [3:0]  r_be_n;
  logic        w_busy;
  logic        w_req;
  logic        w_unused;

  assign w_busy = (r_state == READ) || (r_state == WRITE);
  assign w_req  = ram_read_enable || ram_write_enable;
  assign ram_stall = rst_n &&
    (w_busy || ((r_state == IDLE) && w_req));
  assign w_unused = ^{ram_addr[23:22], ram_addr[1:0], r_be};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_rdata <= 32'd0;
      r_addr  <= 20'd0;
      r_wdata <= 32'd0;
      r_be    <= 4'd0;
      r_dq_oe <= 1'b0;
      r_ce_n  <= 1'b1;
      r_oe_n  <= 1'b1;
      r_we_n  <= 1'b1;
      r_be_n  <= 4'hf;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_req) begin
            r_addr  <= ram_addr[21:2];
            r_wdata <= write_data_to_ram;
            r_be    <= ram_byte_en;
            r_ce_n  <= 1'b0;
          end
          // a write wins when both requests are raised together
          if (ram_write_enable) begin
            r_state <= WRITE;
            r_cnt   <= WR_LOAD;
            r_we_n  <= 1'b0;
            r_dq_oe <= 1'b1;
            r_be_n  <= ~ram_byte_en;
          end else if (ram_read_enable) begin
            r_state <= READ;
            r_cnt   <= RD_LOAD;
            r_oe_n  <= 1'b0;
            r_be_n  <= 4'h0;
          end
        end
        READ: begin
          if (r_cnt == 4'd0) begin
            r_rdata <= sram_dq_i;
            r_state <= DONE;
            r_ce_n  <= 1'b1;
            r_oe_n  <= 1'b1;
            r_be_n  <= 4'hf;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        WRITE: begin
          if (r_cnt == 4'd0) begin
            r_state <= DONE;
            r_ce_n  <= 1'b1;
            r_dq_oe <= 1'b0;
            r_be_n  <= 4'hf;
          end else begin
            r_cnt <= r_cnt - 4'd1;
            // last cycle keeps addr/data stable with we_n high
            if (r_cnt == 4'd1) r_we_n <= 1'b1;
          end
        end
        DONE: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign read_data_from_ram = r_rdata;
  assign sram_addr  = r_addr;
  assign sram_dq_o  = r_wdata;
  assign sram_dq_oe = r_dq_oe;
  assign sram_ce_n  = r_ce_n;
  assign sram_oe_n  = r_oe_n;
  assign sram_we_n  = r_we_n;
  assign sram_be_n  = r_be_n;

endmodule
